// File: rtl/lora_gps_frame_buffer.sv
// lora_gps_frame_buffer
//   Multi-bank frame buffer between the GPS sentence parser (writer) and the
//   LoRa transmit sequencer (reader). The writer fills the current write bank
//   by address and commits it with a length. Committed banks are presented to
//   the reader in FIFO order. The reader reads the head bank with 1-cycle
//   latency, then releases it. A new fix therefore never lands in a bank that
//   is still being transmitted.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   wr_en          write strobe into the current write bank
//   wr_addr        word address within the write bank
//   wr_data        write data
//   wr_commit      close the current write bank as a frame
//   wr_len         frame length in words, sampled with wr_commit
//   wr_ready       a free bank is available for writing
//   wr_bank        index of the current write bank
//   drop_cnt       saturating count of commits rejected because no bank was free
//   rd_valid       at least one committed frame is pending
//   rd_len         length of the head frame (0 while rd_valid is low)
//   rd_bank        index of the head bank
//   rd_addr        word address within the head bank
//   rd_data        registered read data
//   rd_release     free the head bank after transmission
//   frame_count    number of committed, unreleased frames
module lora_gps_frame_buffer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_commit,
  input  logic [ADDR_WIDTH:0]       wr_len,
  output logic                      wr_ready,
  output logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  output logic [7:0]                drop_cnt,
  output logic                      rd_valid,
  output logic [ADDR_WIDTH:0]       rd_len,
  output logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      rd_release,
  output logic [$clog2(NUM_BANKS):0] frame_count
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH  = NUM_BANKS * (2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [BANK_W:0]     BANKS_CNT = (BANK_W + 1)'(NUM_BANKS);

  logic [DATA_WIDTH-1:0] mem     [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   len_reg [0:NUM_BANKS-1];

  logic [BANK_W-1:0] wr_ptr;
  logic [BANK_W-1:0] rd_ptr;
  logic              commit_ok;
  logic              commit_drop;
  logic              rel_ok;

  // Lengths beyond one bank are clamped to the bank depth.
  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign wr_ready    = (frame_count < BANKS_CNT);
  assign rd_valid    = (frame_count != '0);
  assign wr_bank     = wr_ptr;
  assign rd_bank     = rd_ptr;
  assign rd_len      = rd_valid ? len_reg[rd_ptr] : '0;

  // Zero-length commits are ignored outright, so they never count as drops.
  assign commit_ok   = wr_commit && wr_ready && (wr_len != '0);
  assign commit_drop = wr_commit && !wr_ready && (wr_len != '0);
  assign rel_ok      = rd_release && rd_valid;

  // Storage: write port uses the pre-switch wr_ptr, so a write in the same
  // cycle as a commit lands in the bank being closed.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready) begin
      mem[{wr_ptr, wr_addr}] <= wr_data;
    end
    if (commit_ok) begin
      len_reg[wr_ptr] <= clamp_len(wr_len);
    end
  end

  // Control and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_count <= '0;
      drop_cnt    <= '0;
      rd_data     <= '0;
    end else begin
      rd_data <= mem[{rd_ptr, rd_addr}];
      if (commit_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rel_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (commit_ok && !rel_ok) begin
        frame_count <= frame_count + 1'b1;
      end else if (!commit_ok && rel_ok) begin
        frame_count <= frame_count - 1'b1;
      end
      if (commit_drop) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_lora_gps_frame_buffer.sv
module tb_lora_gps_frame_buffer;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int NB = 2;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic [AW:0]   wr_len;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic [7:0]    drop_cnt;
  logic          rd_valid;
  logic [AW:0]   rd_len;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_release;
  logic [BW:0]   frame_count;

  lora_gps_frame_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_BANKS (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_len     (wr_len),
    .wr_ready   (wr_ready),
    .wr_bank    (wr_bank),
    .drop_cnt   (drop_cnt),
    .rd_valid   (rd_valid),
    .rd_len     (rd_len),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_release (rd_release),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; strobes drop after the edge and any pending read is scored.
  task automatic cyc();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    wr_commit  = 1'b0;
    rd_release = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", 32'(rd_data), 32'(e));
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
  endtask

  task automatic commit(input logic [AW:0] len);
    wr_commit = 1'b1; wr_len = len;
    cyc();
  endtask

  task automatic release_head();
    rd_release = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_addr = a;
    exp_q.push_back(e);
    cyc();
  endtask

  task automatic status(input string tag, input int cnt, input int len,
                        input int rbank, input int wbank, input int drop);
    check({tag, ".count"},    32'(frame_count), 32'(cnt));
    check({tag, ".rd_valid"}, 32'(rd_valid),    32'(cnt != 0));
    check({tag, ".wr_ready"}, 32'(wr_ready),    32'(cnt < NB));
    check({tag, ".rd_len"},   32'(rd_len),      32'(len));
    check({tag, ".rd_bank"},  32'(rd_bank),     32'(rbank));
    check({tag, ".wr_bank"},  32'(wr_bank),     32'(wbank));
    check({tag, ".drop"},     32'(drop_cnt),    32'(drop));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
    wr_len = '0; rd_addr = '0; rd_release = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    status("reset", 0, 0, 0, 0, 0);
    check("reset.rd_data", 32'(rd_data), 32'h0);

    // First frame "$GP"
    wr(0, 8'h24); wr(1, 8'h47); wr(2, 8'h50);
    commit(3);
    status("frame1", 1, 3, 0, 1, 0);
    rd(1, 8'h47);
    rd(0, 8'h24);
    release_head();
    status("rel1", 0, 0, 1, 1, 0);
    release_head();
    status("rel_empty", 0, 0, 1, 1, 0);

    // Fill both banks, then a rejected commit and an ignored write
    wr(0, 8'h5A); commit(5);
    status("fill1", 1, 5, 1, 0, 0);
    wr(0, 8'hAA); commit(7);
    status("fill2", 2, 5, 1, 1, 0);
    commit(4);
    status("drop1", 2, 5, 1, 1, 1);
    wr(0, 8'h99);
    rd(0, 8'h5A);
    release_head();
    status("rel2", 1, 7, 0, 1, 1);

    // Write-bank write while reading the head bank at the same address
    wr_en = 1'b1; wr_addr = 0; wr_data = 8'hFF;
    rd(0, 8'hAA);

    // Same-cycle commit and release at count 1; write in that cycle goes to old bank
    wr_en = 1'b1; wr_addr = 1; wr_data = 8'h33;
    wr_commit = 1'b1; wr_len = 9; rd_release = 1'b1;
    cyc();
    status("swap1", 1, 9, 1, 0, 1);
    rd(0, 8'hFF);
    rd(1, 8'h33);

    // Same-cycle commit and release at count 2: commit dropped
    commit(2);
    status("full2", 2, 9, 1, 1, 1);
    wr_commit = 1'b1; wr_len = 3; rd_release = 1'b1;
    cyc();
    status("swap2", 1, 2, 0, 1, 2);

    // Zero-length commit is ignored
    commit(0);
    status("len0", 1, 2, 0, 1, 2);

    // Oversize length is clamped to bank depth
    commit(100);
    release_head();
    status("clamp", 1, 64, 1, 0, 2);

    // Drop counter saturation
    commit(1);
    status("full3", 2, 64, 1, 1, 2);
    for (int i = 0; i < 300; i++) begin
      wr_commit = 1'b1; wr_len = 1;
      cyc();
    end
    status("sat", 2, 64, 1, 1, 255);

    // Reset with two frames pending
    rd_addr = 5;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    status("rst2", 0, 0, 0, 0, 0);
    check("rst2.rd_data", 32'(rd_data), 32'h0);
    wr(3, 8'h3C);
    commit(4);
    status("post_rst", 1, 4, 0, 1, 0);
    rd(3, 8'h3C);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lora_gps_frame_buffer.md
Name: lora_gps_frame_buffer

Overview:
Parametrised multi-bank frame buffer between the GPS sentence parser (writer) and the LoRa transmit sequencer (reader). Storage is split into NUM_BANKS banks, each 2**ADDR_WIDTH words.
- The writer fills one bank by address, then commits it with a length.
- The reader sees committed banks in FIFO order, reads them by address with 1-cycle latency, then releases them.

This replaces single-buffer RAM sharing, so a new GPS fix never overwrites a frame while it is being transmitted.

Parameters:
ADDR_WIDTH, 6, word address width within one bank; bank depth = 2**ADDR_WIDTH.
DATA_WIDTH, 8, word width.
NUM_BANKS, 2, number of banks; power of two, minimum 2.
BANK_W, $clog2(NUM_BANKS), derived (localparam); bank pointer width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe into current write bank
wr_addr  in  ADDR_WIDTH  word address within write bank
wr_data  in  DATA_WIDTH  write data
wr_commit  in  1  close current write bank as a frame
wr_len  in  ADDR_WIDTH+1  frame length in words, sampled with wr_commit
wr_ready  out  1  a free bank is available for writing
wr_bank  out  BANK_W  index of current write bank
drop_cnt  out  8  saturating count of rejected commits
rd_valid  out  1  at least one committed frame is pending
rd_len  out  ADDR_WIDTH+1  length of head frame, valid while rd_valid
rd_bank  out  BANK_W  index of head (read) bank
rd_addr  in  ADDR_WIDTH  word address within head bank
rd_data  out  DATA_WIDTH  registered read data
rd_release  in  1  free head bank after transmission
frame_count  out  BANK_W+1  number of committed, unreleased frames

Behaviour:
- Reset (rst=1 at clock edge):
  - wr_ptr, rd_ptr, frame_count, drop_cnt, rd_data all = 0.
  - rd_valid=0, wr_ready=1, rd_len=0.
  - RAM contents and the length registers are not cleared.
  - Reset asserted mid-frame discards all pending and partially written frames.
- Memory: one array of NUM_BANKS*2**ADDR_WIDTH words, physical address {bank, addr}. One write port, one read port.
- wr_ready = (frame_count < NUM_BANKS), combinational from registered count. wr_bank = wr_ptr.
- Write: if wr_en && wr_ready, then mem[{wr_ptr, wr_addr}] <= wr_data. If wr_ready=0, the write is ignored.
- Commit: accepted iff wr_commit && wr_ready && wr_len != 0.
  - On accept: len_reg[wr_ptr] <= min(wr_len, 2**ADDR_WIDTH); wr_ptr increments modulo NUM_BANKS.
  - wr_commit while wr_ready=0: frame dropped; drop_cnt increments, saturating at 255. wr_ptr and bank contents are unchanged, so the writer must rewrite.
  - wr_commit with wr_len=0: ignored, no counter change.
  - A wr_en in the same cycle as an accepted commit writes to the old bank before the switch.
- rd_valid = (frame_count != 0). rd_bank = rd_ptr. rd_len = len_reg[rd_ptr] when rd_valid, otherwise 0.
- Read: rd_data <= mem[{rd_ptr, rd_addr}] every cycle, giving 1-cycle latency. The bank used is rd_ptr at the sampling edge. Reading while rd_valid=0 returns stale data and is harmless.
- Release: accepted iff rd_release && rd_valid; rd_ptr increments modulo NUM_BANKS. Release while rd_valid=0 is ignored.
- frame_count:
  - +1 on accepted commit only.
  - −1 on accepted release only.
  - Unchanged when both happen in the same cycle; both pointers still advance.
  - Commit acceptance uses wr_ready from before the edge, so a commit with count==NUM_BANKS and a simultaneous release is dropped.
- Bank isolation: the write bank is never the head bank while rd_valid=1 and count<NUM_BANKS. No read/write collision exists within a committed frame.

Test Plan:
- Reset, write bytes 0x24,0x47,0x50 to addr 0..2, commit wr_len=3 → next cycle rd_valid=1, rd_len=3, rd_bank=0, wr_bank=1. rd_addr=1 → rd_data=0x47 one cycle later.
- NUM_BANKS=2: commit two frames (len 5, 7) → wr_ready=0, frame_count=2. Third commit → drop_cnt=1, frame_count stays 2. Release → rd_len=7, wr_ready=1.
- Count=1: commit and release in the same cycle → frame_count stays 1, rd_bank and wr_bank both advance. Count=2 with same-cycle commit+release → commit dropped, drop_cnt+1, count becomes 1.
- Write-bank overwrite during read: write 0xFF to wr_bank addr 0 while reading head bank addr 0 (holding 0xAA) → rd_data=0xAA.
- Edge cases: wr_len=0 commit → no state change. wr_len=100 with ADDR_WIDTH=6 → rd_len=64. rd_release with rd_valid=0 → ignored. 300 rejected commits → drop_cnt=255.
- Assert rst with 2 frames pending → next cycle frame_count=0, rd_valid=0, wr_ready=1, rd_data=0, drop_cnt=0. A subsequent commit lands in bank 0.
